// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// parity-type constants, data width and the parity helper.
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_ODD  = 1'b1;
    localparam logic PAR_EVEN = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity is the XOR of the byte; odd parity is its complement.
    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] data,
                                       input logic typ);
        return (typ == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// Frame sequencer for the UART transmitter. Holds the state register, the
// per-bit cycle counter and the data bit index, and exposes the next-state
// values so the top can register TX_OUT in step with the state.
module uart_tx_fsm
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [5:0] prescale,
    input  logic [5:0] prescale_cap,
    input  logic       par_en_cap,
    output logic       accept,
    output state_t     state_next,
    output logic [2:0] bit_next,
    output logic       busy
);

    state_t     state;
    logic [5:0] cnt;
    logic [5:0] cnt_next;
    logic [2:0] bit_idx;
    logic       bit_done;

    // A new frame is only taken from IDLE with a non-zero bit period.
    assign accept   = (state == IDLE) && req && (prescale != 6'd0);

    // The last cycle of a bit is reached when the counter hits prescale-1.
    assign bit_done = (cnt == (prescale_cap - 6'd1));

    // State, counters and busy flag; busy follows the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            bit_idx <= 3'd0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            busy    <= (state_next != IDLE);
        end
    end

    // Next-state logic; the cycle counter restarts at every bit boundary.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 6'd1;
        bit_next   = bit_idx;
        case (state)
            IDLE: begin
                cnt_next = 6'd0;
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_next   = 6'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_next = 6'd0;
                    bit_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = par_en_cap ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    cnt_next   = 6'd0;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_next   = 6'd0;
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = 6'd0;
                bit_next   = 3'd0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter top: captures the frame parameters on acceptance,
// generates parity from the captured byte and drives the registered line.
module uart_tx
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] data_cap;
    logic                  par_en_cap;
    logic                  par_typ_cap;
    logic [5:0]            prescale_cap;
    logic                  accept;
    state_t                state_next;
    logic [2:0]            bit_next;
    logic                  parity_bit;
    logic                  tx_next;

    uart_tx_fsm u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (DATA_VALID),
        .prescale     (prescale),
        .prescale_cap (prescale_cap),
        .par_en_cap   (par_en_cap),
        .accept       (accept),
        .state_next   (state_next),
        .bit_next     (bit_next),
        .busy         (busy)
    );

    assign parity_bit = parity_of(data_cap, par_typ_cap);

    // Frame parameters are frozen at acceptance so input changes cannot disturb a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_cap     <= '0;
            par_en_cap   <= 1'b0;
            par_typ_cap  <= PAR_EVEN;
            prescale_cap <= 6'd0;
        end else if (accept) begin
            data_cap     <= P_DATA;
            par_en_cap   <= PAR_EN;
            par_typ_cap  <= PAR_TYP;
            prescale_cap <= prescale;
        end
    end

    // Line value for the upcoming state, so the register shows it right after the edge.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = data_cap[bit_next];
            PARITY:  tx_next = parity_bit;
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    // Registered serial output, idle high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            TX_OUT <= 1'b1;
        end else begin
            TX_OUT <= tx_next;
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with these ports:
- clk  in  1  single clock, running at prescale x baud rate (same clock as the receiver).
- rst_n  in  1  synchronous active-low reset.
REQ-002 P_DATA  in  8  byte to transmit; sampled only on acceptance.
REQ-003 DATA_VALID  in  1  transmit request; level-sensitive, qualified by state.
REQ-004 PAR_EN  in  1  1 = parity bit appended; sampled on acceptance.
REQ-005 PAR_TYP  in  1  1 = odd parity, 0 = even parity; sampled on acceptance.
REQ-006 prescale  in  6  clk cycles per serial bit; sampled on acceptance; legal values 8, 16, 32.
REQ-007 TX_OUT  out  1  serial line, registered, idle high.
REQ-008 busy  out  1  registered; high from the cycle after acceptance through the final stop-bit cycle.

Function
REQ-009 Frame format SHALL be: start (0), P_DATA[0]..P_DATA[7] LSB first, optional parity, stop (1).
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE->START on acceptance.
- START->DATA after prescale cycles.
- DATA->PARITY, or DATA->STOP when PAR_EN=0, after 8 bits.
- PARITY->STOP after one bit.
- STOP->IDLE after prescale cycles.
REQ-011 Acceptance SHALL occur on a rising edge where state=IDLE, DATA_VALID=1 and prescale!=0.
- Accepting captures P_DATA, PAR_EN, PAR_TYP and prescale into internal registers.
- DATA_VALID in any other state SHALL be ignored, with no queuing.
REQ-012 Latency: if acceptance occurs on edge N, TX_OUT=0 and busy=1 SHALL be visible after edge N.
REQ-013 Each bit SHALL be held for exactly captured-prescale clk cycles, timed by a 6-bit cycle counter that restarts at every bit boundary.
REQ-014 A 3-bit bit index SHALL select the data bit; it wraps from 7 to 0 on leaving DATA.
REQ-015 Parity bit SHALL be ^data for even and ~^data for odd, computed from the captured byte.
REQ-016 Frame duration in busy cycles SHALL be (10+PAR_EN) x prescale.
- After STOP, at least one IDLE cycle (TX_OUT=1, busy=0) SHALL precede the next START.
REQ-017 Input changes during a frame (P_DATA, PAR_EN, PAR_TYP, prescale) SHALL NOT affect the frame in progress.
REQ-018 prescale=0 in IDLE SHALL block acceptance; TX_OUT stays 1.
REQ-019 DATA_VALID held high continuously SHALL produce back-to-back frames separated by exactly one IDLE cycle.

Reset
REQ-020 On rst_n=0 at a rising edge, the following SHALL hold after that edge:
- state=IDLE, TX_OUT=1, busy=0.
- counters=0, captured registers=0.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately; no partial bits SHALL follow after reset release.

Structure
REQ-022 Package uart_pkg SHALL hold:
- the FSM state encoding;
- parity-type constants (PAR_ODD=1, PAR_EVEN=0);
- the data width constant (8).
REQ-023 One sub-module, uart_tx_fsm, SHALL contain the state register and the bit/cycle counters.
- The top SHALL hold the capture registers, parity generator and TX_OUT mux.

Verification
REQ-024 Even-parity frame: 0xA5, PAR_EN=1, PAR_TYP=0, prescale=8 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles; busy high for 88 cycles.
REQ-025 Odd-parity frame: 0xA5, PAR_TYP=1, prescale=32 -> parity bit=1; busy high for 352 cycles.
REQ-026 No-parity frame: 0x3C, PAR_EN=0, prescale=16 -> 10 bits, 160 busy cycles, stop bit immediately after P_DATA[7].
REQ-027 Ignored request: DATA_VALID pulse with 0xFF during bit 3 of a frame -> no effect on the current frame; no second frame follows.
REQ-028 Reset mid-frame: rst_n=0 during DATA -> TX_OUT=1 and busy=0 after the next edge; IDLE persists with DATA_VALID=0.
REQ-029 Loopback into the receiver: 10 random bytes at each prescale 8/16/32 with random parity settings -> receiver P_DATA matches each byte, par_err=0, stp_err=0.
